// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers with completer wait states and an optional wait-state timeout.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] SAT  = '1;

   state_t          state;
   state_t          state_n;
   logic [CW-1:0]   wait_cnt;
   logic            accept;
   logic            done;
   logic            abort;

   assign cmd_ready = (state == IDLE) || ((state == ACCESS) && PREADY);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_n = state;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) state_n = SETUP;
         end
         SETUP: begin
            state_n = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               done    = 1'b1;
               state_n = cmd_valid ? SETUP : IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == LAST)) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
         wait_cnt    <= '0;
      end else begin
         state     <= state_n;
         PSEL      <= (state_n != IDLE);
         PENABLE   <= (state_n == ACCESS);
         rsp_valid <= done || abort;
         if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
         if (done) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
         end
         // counts stalled ACCESS cycles; saturates rather than wrapping
         if (state == SETUP) begin
            wait_cnt <= '0;
         end else if ((state == ACCESS) && !PREADY && (wait_cnt != SAT)) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

endmodule
